// File: rtl/mode_blink_indicator_pkg.sv
// Shared types and defaults for the mode blink indicator and the mode selector
// that feeds it.
package mode_blink_indicator_pkg;

    localparam int unsigned MODE_W_DEFAULT     = 4;
    localparam int unsigned ON_CYCLES_DEFAULT  = 20000;
    localparam int unsigned OFF_CYCLES_DEFAULT = 20000;
    localparam int unsigned GAP_CYCLES_DEFAULT = 80000;

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StOff,
        StGap
    } blink_state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mode_blink_indicator_timer.sv
// Phase timer: up-counter restarted at zero on demand, flags when it reaches the
// terminal value supplied for the current phase.
module phase_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             restart_i,
    input  logic [Width-1:0] term_i,
    output logic             tc_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = restart_i ? '0 : count_q + Width'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == term_i);

endmodule

// File: rtl/mode_blink_indicator.sv
// Shows the current mode on one LED as a repeating code of mode+1 blinks
// followed by a dark gap.
module mode_blink_indicator
    import mode_blink_indicator_pkg::*;
#(
    parameter int unsigned MODE_W     = MODE_W_DEFAULT,
    parameter int unsigned ON_CYCLES  = ON_CYCLES_DEFAULT,
    parameter int unsigned OFF_CYCLES = OFF_CYCLES_DEFAULT,
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] mode,
    output logic              led,
    output logic              frame_done,
    output logic [MODE_W-1:0] active_mode
);

    localparam int unsigned MaxCycles = max3(ON_CYCLES, OFF_CYCLES, GAP_CYCLES);
    localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam int unsigned BlinkW    = MODE_W + 1;

    blink_state_e      state_q, state_d;
    logic              led_q, led_d;
    logic              frame_done_q, frame_done_d;
    logic [MODE_W-1:0] active_mode_q, active_mode_d;
    logic [BlinkW-1:0] blinks_left_q, blinks_left_d;

    logic              restart;
    logic              tc;
    logic [TimerW-1:0] term;
    logic              mode_changed;

    always_comb begin
        term = TimerW'(GAP_CYCLES - 1);
        if (state_q == StOn) begin
            term = TimerW'(ON_CYCLES - 1);
        end else if (state_q == StOff) begin
            term = TimerW'(OFF_CYCLES - 1);
        end
    end

    phase_timer #(
        .Width (TimerW)
    ) u_phase_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .restart_i (restart),
        .term_i    (term),
        .tc_o      (tc)
    );

    assign mode_changed = (mode != active_mode_q);

    always_comb begin
        state_d       = state_q;
        led_d         = led_q;
        frame_done_d  = 1'b0;
        active_mode_d = active_mode_q;
        blinks_left_d = blinks_left_q;
        restart       = 1'b0;
        unique case (state_q)
            StIdle: begin
                active_mode_d = mode;
                blinks_left_d = BlinkW'(mode) + BlinkW'(1);
                led_d         = 1'b1;
                state_d       = StOn;
                restart       = 1'b1;
            end
            StOn: begin
                // A new request cuts the code short; the full gap still follows.
                if (mode_changed) begin
                    led_d   = 1'b0;
                    state_d = StGap;
                    restart = 1'b1;
                end else if (tc) begin
                    led_d         = 1'b0;
                    blinks_left_d = blinks_left_q - BlinkW'(1);
                    state_d       = StOff;
                    restart       = 1'b1;
                end
            end
            StOff: begin
                if (mode_changed) begin
                    led_d   = 1'b0;
                    state_d = StGap;
                    restart = 1'b1;
                end else if (tc) begin
                    restart = 1'b1;
                    if (blinks_left_q == '0) begin
                        state_d = StGap;
                    end else begin
                        led_d   = 1'b1;
                        state_d = StOn;
                    end
                end
            end
            StGap: begin
                if (tc) begin
                    frame_done_d  = 1'b1;
                    active_mode_d = mode;
                    blinks_left_d = BlinkW'(mode) + BlinkW'(1);
                    led_d         = 1'b1;
                    state_d       = StOn;
                    restart       = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                restart = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            led_q         <= 1'b0;
            frame_done_q  <= 1'b0;
            active_mode_q <= '0;
            blinks_left_q <= '0;
        end else begin
            state_q       <= state_d;
            led_q         <= led_d;
            frame_done_q  <= frame_done_d;
            active_mode_q <= active_mode_d;
            blinks_left_q <= blinks_left_d;
        end
    end

    assign led         = led_q;
    assign frame_done  = frame_done_q;
    assign active_mode = active_mode_q;

endmodule
